// File: rtl/net_stream_pkg.sv
`default_nettype none
// ============================================================================
// net_stream_pkg : shared types for the network input streamer
// Rev 1.0
// ============================================================================
package net_stream_pkg;

  localparam int T_DEF = 16;

  typedef logic signed [T_DEF-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } streamer_state_e;

endpackage
`default_nettype wire

// File: rtl/net_stream_buf.sv
`default_nettype none
// ============================================================================
// net_stream_buf : DEPTH x T register array, one write port, registered read
// Rev 1.0
// ============================================================================
module net_stream_buf
  import net_stream_pkg::*;
#(
  parameter int T     = T_DEF,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic signed [T-1:0] wr_data_i,
  input  logic                rd_en_i,
  input  logic [AW-1:0]       rd_addr_i,
  output logic signed [T-1:0] rd_data_o
);

  logic signed [T-1:0] mem_q [DEPTH];
  logic signed [T-1:0] rd_data_q;
  logic                w_wr_ok;

  generate
    if (DEPTH == (1 << AW)) begin : g_addr_full
      assign w_wr_ok = wr_en_i;
    end else begin : g_addr_partial
      assign w_wr_ok = wr_en_i && (wr_addr_i < AW'(DEPTH));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr_ok) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Same-cycle write bypass so a write issued alongside start is seen by the first read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= (w_wr_ok && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/net_input_streamer.sv
`default_nettype none
// ============================================================================
// net_input_streamer : buffers host-written vectors and streams them out over
// valid/ready. Optional macro NET_STREAMER_STALL_CNT_EN adds stall_cycles.
// Rev 1.0
// ============================================================================
module net_input_streamer
  import net_stream_pkg::*;
#(
  parameter int T       = T_DEF,
  parameter int VEC_LEN = 4,
  parameter int NUM_VEC = 8,
  parameter int DEPTH   = VEC_LEN * NUM_VEC,
  parameter int AW      = $clog2(DEPTH),
  parameter int VW      = $clog2(NUM_VEC + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [T-1:0] wr_data,
  input  logic                start,
  input  logic [VW-1:0]       num_vec,
  output logic                busy,
  output logic                done,
  output logic                output_valid,
  input  logic                output_ready,
  output logic signed [T-1:0] output_data
`ifdef NET_STREAMER_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int LW = $clog2(DEPTH + 1);

  streamer_state_e state_q, state_d;
  logic [LW-1:0]   ptr_q, ptr_d;
  logic [LW-1:0]   limit_q, limit_d;
  logic            w_start_ok;
  logic            w_last;
  logic            w_wr_en;
  logic            w_rd_en;
  logic [AW-1:0]   w_rd_addr;

  assign w_start_ok = start && (num_vec != '0) && (num_vec <= VW'(NUM_VEC));
  assign w_last     = (ptr_q == (limit_q - LW'(1)));
  assign w_wr_en    = wr_en && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    limit_d   = limit_q;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    case (state_q)
      IDLE: begin
        if (w_start_ok) begin
          state_d = STREAM;
          ptr_d   = '0;
          limit_d = LW'(num_vec) * LW'(VEC_LEN);
          w_rd_en = 1'b1;
        end
      end
      STREAM: begin
        // Prefetch the next element on acceptance so ready held high gives no bubble.
        if (output_ready) begin
          if (w_last) begin
            state_d = DONE;
          end else begin
            ptr_d     = ptr_q + LW'(1);
            w_rd_en   = 1'b1;
            w_rd_addr = AW'(ptr_q + LW'(1));
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      limit_q <= limit_d;
    end
  end

  assign busy         = (state_q == STREAM);
  assign output_valid = (state_q == STREAM);
  assign done         = (state_q == DONE);

  net_stream_buf #(
    .T     (T),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (w_rd_en),
    .rd_addr_i (w_rd_addr),
    .rd_data_o (output_data)
  );

`ifdef NET_STREAMER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && w_start_ok) begin
      stall_q <= '0;
    end else if ((state_q == STREAM) && !output_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_net_input_streamer.sv
`default_nettype none
// ============================================================================
// tb_net_input_streamer : directed scoreboard bench for net_input_streamer
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_net_input_streamer;

  localparam int T       = 16;
  localparam int VEC_LEN = 4;
  localparam int NUM_VEC = 8;
  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int VW      = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic signed [T-1:0] wr_data = '0;
  logic                start = 1'b0;
  logic [VW-1:0]       num_vec = '0;
  logic                output_ready = 1'b0;
  logic                busy, done, output_valid;
  logic signed [T-1:0] output_data;
`ifdef NET_STREAMER_STALL_CNT_EN
  logic [31:0]         stall_cycles;
`endif

  logic signed [T-1:0] model_mem [DEPTH];
  logic signed [T-1:0] sbq [$];
  int checks = 0;
  int errors = 0;
  int stalls = 0;

  always #5 clk = ~clk;

  net_input_streamer #(
    .T       (T),
    .VEC_LEN (VEC_LEN),
    .NUM_VEC (NUM_VEC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .num_vec      (num_vec),
    .busy         (busy),
    .done         (done),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
`ifdef NET_STREAMER_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic signed [T-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic launch(input int nv);
    start = 1'b1;
    num_vec = VW'(nv);
    if (nv >= 1 && nv <= NUM_VEC) begin
      stalls = 0;
      for (int i = 0; i < nv * VEC_LEN; i++) sbq.push_back(model_mem[i]);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(output_valid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
  task automatic stream(input int mode, input int abort_after, input bit start_in_done);
    int   cyc = 0;
    int   acc = 0;
    logic rdy;
    while (sbq.size() > 0 && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      output_ready = rdy;
      @(negedge clk);
      chk("stream_valid", 32'(output_valid), 32'd1);
      chk("stream_busy", 32'(busy), 32'd1);
      chk("stream_done", 32'(done), 32'd0);
      if (output_valid) begin
        chk("data", 32'(output_data), 32'(sbq[0]));
        if (rdy) begin
          void'(sbq.pop_front());
          acc++;
        end else begin
          stalls++;
        end
      end
      cyc++;
      @(posedge clk);
      #1;
      if (abort_after > 0 && acc == abort_after) return;
    end
    output_ready = 1'b0;
    chk("timeout_left", 32'(sbq.size()), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_valid", 32'(output_valid), 32'd0);
    if (start_in_done) begin
      start = 1'b1;
      num_vec = VW'(1);
    end
    tick();
    start = 1'b0;
    idle_checks("post_done");
`ifdef NET_STREAMER_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, 32'(stalls));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    tick();
    tick();
    idle_checks("reset");
    chk("reset_data", 32'(output_data), 32'd0);
`ifdef NET_STREAMER_STALL_CNT_EN
    chk("reset_stall", stall_cycles, 32'd0);
`endif
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 16'(i + 1);
      host_write(AW'(i), 16'(i + 1));
    end

    // Back-to-back stream of two vectors, then ready toggling with a start in DONE.
    launch(2);
    stream(0, 0, 1'b0);
    launch(2);
    stream(1, 0, 1'b1);

    // Out-of-range vector counts are ignored.
    launch(0);
    idle_checks("nv0");
    tick();
    idle_checks("nv0_later");
    launch(9);
    idle_checks("nv9");
    tick();
    idle_checks("nv9_later");
    launch(15);
    idle_checks("nv15");

    launch(1);
    stream(0, 0, 1'b0);

    // Reset after the third acceptance aborts the run without done.
    launch(2);
    stream(0, 3, 1'b0);
    reset = 1'b0;
    tick();
    idle_checks("abort");
    chk("abort_data", 32'(output_data), 32'd0);
    reset = 1'b1;
    sbq.delete();
    tick();
    idle_checks("abort_later");
    launch(1);
    stream(0, 0, 1'b0);

    // Write and start while streaming are both dropped.
    launch(1);
    output_ready = 1'b0;
    wr_en = 1'b1; wr_addr = '0; wr_data = 16'sh7FFF;
    start = 1'b1; num_vec = VW'(2);
    stalls++;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    stream(0, 0, 1'b0);
    launch(1);
    stream(0, 0, 1'b0);

    // Write together with start in IDLE is seen by the first element.
    wr_en = 1'b1; wr_addr = '0; wr_data = 16'sh7FFF;
    model_mem[0] = 16'sh7FFF;
    launch(1);
    wr_en = 1'b0;
    stream(0, 0, 1'b0);

    // Full buffer with random data and random back-pressure.
    for (int i = 0; i < DEPTH; i++) begin
      logic signed [T-1:0] d;
      d = T'($urandom);
      model_mem[i] = d;
      host_write(AW'(i), d);
    end
    launch(NUM_VEC);
    stream(2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
